// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, geometry defaults and address-field helpers for the icache refill path
//
// Purpose: the refill FSM state type, the default cache geometry (OW/IW/TW
// derived from it), and helpers that split a fetch address into
// word-offset / line-index / tag fields or line-align it.
// The helpers take the field widths as arguments, so a controller built with
// non-default parameters reuses them unchanged. Addresses are widened to
// 64 bits on the way in and the caller slices the result back down.
// Ports: none (package).
package icache_pkg;

  typedef enum logic [1:0] {
    LOOKUP,
    MISS_REQ,
    REFILL,
    UPDATE
  } state_t;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINES_DEF      = 64;
  localparam int LINE_WORDS_DEF = 4;

  localparam int OW = $clog2(LINE_WORDS_DEF);
  localparam int IW = $clog2(LINES_DEF);
  localparam int TW = ADDR_WIDTH_DEF - IW - OW - 2;

  typedef logic [63:0] xaddr_t;

  function automatic xaddr_t field_mask(input int width);
    return (xaddr_t'(1) << width) - xaddr_t'(1);
  endfunction

  // word offset inside the line: addr[ow+1:2]
  function automatic xaddr_t addr_offset(input xaddr_t addr, input int ow);
    return (addr >> 2) & field_mask(ow);
  endfunction

  // line index: addr[iw+ow+1:ow+2]
  function automatic xaddr_t addr_index(input xaddr_t addr, input int ow, input int iw);
    return (addr >> (ow + 2)) & field_mask(iw);
  endfunction

  // tag: everything above the index
  function automatic xaddr_t addr_tag(input xaddr_t addr, input int ow, input int iw);
    return addr >> (iw + ow + 2);
  endfunction

  // clear the byte and word-offset bits so the address points at the first word of its line
  function automatic xaddr_t line_align(input xaddr_t addr, input int ow);
    return addr & ~field_mask(ow + 2);
  endfunction

endpackage

// File: rtl/icache_refill_controller_if.sv
// rtl/icache_refill_controller_if.sv - line-fill handshake between the icache controller and memory
//
// Purpose: bundles the memory-side refill request/response signals.
// Ports (signals):
//   MEM_REQ        line-fill request, held until MEM_ACK
//   MEM_ADDR       line-aligned miss address
//   MEM_ACK        request accepted
//   MEM_DATA       refill beat
//   MEM_DATA_VALID beat present this cycle
// Modports: master = cache controller, slave = memory system.
interface icache_refill_controller_if
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  MEM_REQ;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic                  MEM_ACK;
  logic [31:0]           MEM_DATA;
  logic                  MEM_DATA_VALID;

  modport master (
    output MEM_REQ,
    output MEM_ADDR,
    input  MEM_ACK,
    input  MEM_DATA,
    input  MEM_DATA_VALID
  );

  modport slave (
    input  MEM_REQ,
    input  MEM_ADDR,
    output MEM_ACK,
    output MEM_DATA,
    output MEM_DATA_VALID
  );

endinterface

// File: rtl/icache_tag_array.sv
// rtl/icache_tag_array.sv - tag store and valid vector for the direct-mapped icache
//
// Purpose: LINES x TW tag registers plus one valid bit per line.
// Ports:
//   clk        clock
//   clear      synchronous clear of every valid bit (reset or flush); wins over valid_set
//   rd_index   combinational read port index
//   rd_tag     tag stored at rd_index
//   rd_valid   valid bit at rd_index
//   tag_we     write wr_tag into line wr_index
//   wr_index   tag write index
//   wr_tag     tag write data
//   valid_set  set valid bit of line set_index
//   set_index  valid set index
// The tag registers are never reset; only the valid bits qualify them.
module icache_tag_array #(
  parameter int LINES = 64,
  parameter int IW    = 6,
  parameter int TW    = 22
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [IW-1:0] rd_index,
  output logic [TW-1:0] rd_tag,
  output logic          rd_valid,
  input  logic          tag_we,
  input  logic [IW-1:0] wr_index,
  input  logic [TW-1:0] wr_tag,
  input  logic          valid_set,
  input  logic [IW-1:0] set_index
);

  logic [TW-1:0]    tags [LINES];
  logic [LINES-1:0] valid;

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tags[wr_index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
    end else if (valid_set) begin
      valid[set_index] <= 1'b1;
    end
  end

  assign rd_tag   = tags[rd_index];
  assign rd_valid = valid[rd_index];

endmodule

// File: rtl/icache_refill_controller.sv
// rtl/icache_refill_controller.sv - miss detection and line-refill sequencer for the direct-mapped icache
//
// Purpose: looks up the fetch PC in the tag array, reports hits to fetch,
// and on a miss requests the line from memory, streams the returned beats
// into the external data RAM and then validates the line. Handles whole-cache
// invalidation (FLUSH), deferring it to the end of an in-flight refill.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   PC, PC_VALID             fetch address and request qualifier
//   INSTRUCTION_CACHE_STALL  blocks launching a new refill
//   FLUSH                    invalidate all lines
//   INSTRUCTION_CACHE_READY  data RAM output at DATA_RADDR is a valid hit
//   DATA_RADDR               {index, offset} of PC, combinational
//   DATA_WE/WADDR/WDATA      data RAM write port fed by refill beats
//   mem                      memory line-fill handshake (master side)
//   REFILL_BUSY              FSM is not in LOOKUP
module icache_refill_controller
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic [ADDR_WIDTH-1:0]                        PC,
  input  logic                                         PC_VALID,
  input  logic                                         INSTRUCTION_CACHE_STALL,
  input  logic                                         FLUSH,
  output logic                                         INSTRUCTION_CACHE_READY,
  output logic [$clog2(LINES)+$clog2(LINE_WORDS)-1:0]  DATA_RADDR,
  output logic                                         DATA_WE,
  output logic [$clog2(LINES)+$clog2(LINE_WORDS)-1:0]  DATA_WADDR,
  output logic [31:0]                                  DATA_WDATA,
  icache_refill_controller_if.master                   mem,
  output logic                                         REFILL_BUSY
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   miss_addr;
  logic [OFF_W-1:0]        beat_cnt;
  logic                    pending_flush;
  logic                    mem_req_q;

  logic [OFF_W-1:0]        pc_off;
  logic [IDX_W-1:0]        pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic [IDX_W-1:0]        miss_idx;
  logic [TAG_W-1:0]        miss_tag;
  logic [ADDR_WIDTH-1:0]   pc_line;

  logic [TAG_W-1:0]        rd_tag;
  logic                    rd_valid;
  logic                    hit;
  logic                    last_beat;
  logic                    beat_write;
  logic                    clear_all;
  logic                    valid_set;

  assign pc_off   = OFF_W'(addr_offset(xaddr_t'(PC), OFF_W));
  assign pc_idx   = IDX_W'(addr_index(xaddr_t'(PC), OFF_W, IDX_W));
  assign pc_tag   = TAG_W'(addr_tag(xaddr_t'(PC), OFF_W, IDX_W));
  assign pc_line  = ADDR_WIDTH'(line_align(xaddr_t'(PC), OFF_W));
  assign miss_idx = IDX_W'(addr_index(xaddr_t'(miss_addr), OFF_W, IDX_W));
  assign miss_tag = TAG_W'(addr_tag(xaddr_t'(miss_addr), OFF_W, IDX_W));

  assign hit       = PC_VALID & rd_valid & (rd_tag == pc_tag);
  assign last_beat = (beat_cnt == OFF_W'(LINE_WORDS - 1));

  // Beats are gated by RST so a beat landing in the reset cycle of an
  // abandoned refill never reaches the data RAM or the tag store.
  assign beat_write = (state == REFILL) & mem.MEM_DATA_VALID & ~RST;

  // A flush seen in UPDATE itself is folded into the deferred flush so it is
  // not lost when pending_flush is cleared on the way back to LOOKUP.
  assign clear_all = RST
                   | ((state == LOOKUP) & FLUSH)
                   | ((state == UPDATE) & (pending_flush | FLUSH));
  assign valid_set = (state == UPDATE) & ~pending_flush & ~FLUSH;

  icache_tag_array #(
    .LINES (LINES),
    .IW    (IDX_W),
    .TW    (TAG_W)
  ) u_tag_array (
    .clk       (CLK),
    .clear     (clear_all),
    .rd_index  (pc_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .tag_we    (beat_write & last_beat),
    .wr_index  (miss_idx),
    .wr_tag    (miss_tag),
    .valid_set (valid_set),
    .set_index (miss_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= LOOKUP;
      mem_req_q     <= 1'b0;
      beat_cnt      <= '0;
      pending_flush <= 1'b0;
    end else begin
      case (state)
        LOOKUP: begin
          if (!FLUSH && PC_VALID && !hit && !INSTRUCTION_CACHE_STALL) begin
            miss_addr <= pc_line;
            mem_req_q <= 1'b1;
            state     <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (FLUSH) begin
            pending_flush <= 1'b1;
          end
          if (mem.MEM_ACK) begin
            mem_req_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (FLUSH) begin
            pending_flush <= 1'b1;
          end
          if (mem.MEM_DATA_VALID) begin
            beat_cnt <= beat_cnt + OFF_W'(1);
            if (last_beat) begin
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          pending_flush <= 1'b0;
          state         <= LOOKUP;
        end
        default: begin
          state <= LOOKUP;
        end
      endcase
    end
  end

  assign mem.MEM_REQ  = mem_req_q;
  assign mem.MEM_ADDR = miss_addr;

  assign INSTRUCTION_CACHE_READY = (state == LOOKUP) & hit & ~FLUSH;
  assign DATA_RADDR  = {pc_idx, pc_off};
  assign DATA_WE     = beat_write;
  assign DATA_WADDR  = {miss_idx, beat_cnt};
  assign DATA_WDATA  = mem.MEM_DATA;
  assign REFILL_BUSY = (state != LOOKUP);

endmodule

// File: tb/tb_icache_refill_controller.sv
// tb/tb_icache_refill_controller.sv - directed self-checking bench for icache_refill_controller
module tb_icache_refill_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic        PC_VALID;
  logic        STALL;
  logic        FLUSH;
  logic        READY;
  logic [7:0]  DATA_RADDR;
  logic        DATA_WE;
  logic [7:0]  DATA_WADDR;
  logic [31:0] DATA_WDATA;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int cyc    = 0;
  logic [39:0] sb [$];

  always #5 CLK = ~CLK;

  icache_refill_controller_if #(.ADDR_WIDTH(32)) mem_if ();

  icache_refill_controller #(
    .ADDR_WIDTH (32),
    .LINES      (64),
    .LINE_WORDS (4)
  ) dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .PC                      (PC),
    .PC_VALID                (PC_VALID),
    .INSTRUCTION_CACHE_STALL (STALL),
    .FLUSH                   (FLUSH),
    .INSTRUCTION_CACHE_READY (READY),
    .DATA_RADDR              (DATA_RADDR),
    .DATA_WE                 (DATA_WE),
    .DATA_WADDR              (DATA_WADDR),
    .DATA_WDATA              (DATA_WDATA),
    .mem                     (mem_if),
    .REFILL_BUSY             (BUSY)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // every data RAM write must match the oldest expected beat
  always @(negedge CLK) begin
    if (DATA_WE === 1'b1) begin
      logic [39:0] e;
      we_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed waddr %0h wdata %0h required no write", DATA_WADDR, DATA_WDATA);
      end else begin
        e = sb.pop_front();
        chk("write", {DATA_WADDR, DATA_WDATA}, e);
      end
    end
  end

  task automatic scramble();
    PC       = 32'h0000_7000 | ($urandom & 32'h0000_0FF0);
    PC_VALID = 1'($urandom_range(0, 1));
    STALL    = 1'($urandom_range(0, 1));
  endtask

  // Entered in the first cycle MEM_REQ is expected high; returns in the UPDATE cycle.
  task automatic serve(input logic [31:0] exp_addr, input int ack_dly, input int gap,
                       input logic [31:0] d0, input logic [5:0] idx, input int flush_beat,
                       input bit scr, input logic [31:0] pc_back);
    int w0;
    w0 = we_cnt;
    for (int i = 0; i < ack_dly; i++) begin
      chk("req_hold", mem_if.MEM_REQ, 1);
      chk("addr_hold", mem_if.MEM_ADDR, exp_addr);
      chk("ready_in_req", READY, 0);
      if (scr) scramble();
      step();
    end
    chk("req_at_ack", mem_if.MEM_REQ, 1);
    chk("addr_at_ack", mem_if.MEM_ADDR, exp_addr);
    mem_if.MEM_ACK = 1'b1;
    step();
    mem_if.MEM_ACK = 1'b0;
    chk("req_drop", mem_if.MEM_REQ, 0);
    chk("busy_refill", BUSY, 1);
    for (int b = 0; b < 4; b++) begin
      mem_if.MEM_DATA_VALID = 1'b1;
      mem_if.MEM_DATA       = d0 + 32'(b);
      sb.push_back({idx, 2'(b), d0 + 32'(b)});
      FLUSH = (b == flush_beat);
      step();
      FLUSH = 1'b0;
      mem_if.MEM_DATA_VALID = 1'b0;
      mem_if.MEM_DATA       = 32'hDEAD_BEEF;
      if (b < 3) begin
        for (int g = 0; g < gap; g++) begin
          if (scr) scramble();
          #1;
          chk("ready_in_refill", READY, 0);
          step();
        end
      end
    end
    PC       = pc_back;
    PC_VALID = 1'b1;
    STALL    = 1'b0;
    #1;
    chk("busy_update", BUSY, 1);
    chk("ready_update", READY, 0);
    chk("we_count", 40'(we_cnt - w0), 4);
  endtask

  initial begin
    int c0;
    int n;
    RST = 1'b1; PC = 32'h0; PC_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    mem_if.MEM_ACK = 1'b0; mem_if.MEM_DATA = 32'h0; mem_if.MEM_DATA_VALID = 1'b0;
    step(); step(); step();
    chk("rst_busy", BUSY, 0);
    chk("rst_req", mem_if.MEM_REQ, 0);
    chk("rst_we", DATA_WE, 0);
    chk("rst_ready", READY, 0);
    RST = 1'b0;
    step();

    // cold miss, held off by stall first
    PC = 32'h0000_1004; PC_VALID = 1'b1; STALL = 1'b1;
    #1;
    chk("cold_ready", READY, 0);
    chk("cold_raddr", DATA_RADDR, 8'h01);
    STALL = 1'b0;
    c0 = cyc;
    step();
    chk("cold_req", mem_if.MEM_REQ, 1);
    chk("cold_busy", BUSY, 1);
    serve(32'h0000_1000, 0, 0, 32'hA0, 6'd0, -1, 1'b0, 32'h0000_1004);
    n = 0;
    while (READY !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("cold_latency", 40'(cyc - c0), 7);
    chk("cold_hit_raddr", DATA_RADDR, 8'h01);

    // hit on another word of the line, then same index with another tag
    PC = 32'h0000_100C;
    #1;
    chk("hit_ready", READY, 1);
    chk("hit_raddr", DATA_RADDR, 8'h03);
    step();
    chk("hit_no_req", mem_if.MEM_REQ, 0);
    chk("hit_not_busy", BUSY, 0);
    PC = 32'h0000_200C;
    #1;
    chk("conflict_ready", READY, 0);
    step();
    chk("conflict_req", mem_if.MEM_REQ, 1);
    serve(32'h0000_2000, 3, 2, 32'hB0, 6'd0, -1, 1'b1, 32'h0000_200C);
    step();
    chk("bubble_hit", READY, 1);
    PC = 32'h0000_1004; STALL = 1'b1;
    #1;
    chk("evicted_miss", READY, 0);

    // stall gating
    PC = 32'h0000_3010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_req", mem_if.MEM_REQ, 0);
      chk("stall_ready", READY, 0);
      chk("stall_busy", BUSY, 0);
    end
    STALL = 1'b0;
    step();
    chk("unstall_req", mem_if.MEM_REQ, 1);
    serve(32'h0000_3010, 0, 0, 32'hC0, 6'd1, -1, 1'b0, 32'h0000_3010);
    step();
    chk("stall_line_hit", READY, 1);
    chk("stall_line_raddr", DATA_RADDR, 8'h04);

    // flush on the second beat of a refill
    PC = 32'h0000_4020;
    #1;
    chk("flush_line_cold", READY, 0);
    step();
    chk("flush_line_req", mem_if.MEM_REQ, 1);
    serve(32'h0000_4020, 1, 1, 32'hD0, 6'd2, 1, 1'b0, 32'h0000_4020);
    STALL = 1'b1;
    step();
    chk("pending_flush_miss", READY, 0);
    chk("pending_flush_idle", BUSY, 0);
    PC = 32'h0000_3010;
    #1;
    chk("flush_all_lines", READY, 0);
    PC = 32'h0000_4020; STALL = 1'b0;
    step();
    chk("refetch_req", mem_if.MEM_REQ, 1);
    serve(32'h0000_4020, 0, 0, 32'hD8, 6'd2, -1, 1'b0, 32'h0000_4020);
    step();
    chk("refetch_hit", READY, 1);

    // flush in LOOKUP after a hit
    FLUSH = 1'b1;
    #1;
    chk("ready_during_flush", READY, 0);
    step();
    FLUSH = 1'b0;
    #1;
    chk("post_flush_miss", READY, 0);
    chk("flush_blocks_launch", mem_if.MEM_REQ, 0);
    step();
    chk("post_flush_req", mem_if.MEM_REQ, 1);
    serve(32'h0000_4020, 0, 0, 32'hE0, 6'd2, -1, 1'b0, 32'h0000_4020);
    step();
    chk("post_flush_hit", READY, 1);

    // reset in the middle of a refill
    PC = 32'h0000_5030;
    step();
    chk("rstmid_req", mem_if.MEM_REQ, 1);
    mem_if.MEM_ACK = 1'b1;
    step();
    mem_if.MEM_ACK = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_if.MEM_DATA_VALID = 1'b1;
      mem_if.MEM_DATA       = 32'hF0 + 32'(b);
      sb.push_back({6'd3, 2'(b), 32'hF0 + 32'(b)});
      step();
    end
    mem_if.MEM_DATA_VALID = 1'b0;
    PC_VALID = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rstmid_req_drop", mem_if.MEM_REQ, 0);
    chk("rstmid_idle", BUSY, 0);
    for (int b = 2; b < 4; b++) begin
      mem_if.MEM_DATA_VALID = 1'b1;
      mem_if.MEM_DATA       = 32'hF0 + 32'(b);
      #1;
      chk("rstmid_no_we", DATA_WE, 0);
      step();
    end
    mem_if.MEM_DATA_VALID = 1'b0;
    PC_VALID = 1'b1;
    #1;
    chk("rstmid_miss", READY, 0);
    step();
    chk("rstmid_rereq", mem_if.MEM_REQ, 1);
    chk("rstmid_addr", mem_if.MEM_ADDR, 32'h0000_5030);
    serve(32'h0000_5030, 0, 0, 32'hF8, 6'd3, -1, 1'b0, 32'h0000_5030);
    step();
    chk("rstmid_hit", READY, 1);
    PC = 32'h0000_4020; STALL = 1'b1;
    #1;
    chk("rst_cleared_valid", READY, 0);

    step();
    chk("sb_empty", 40'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
Miss/refill sequencer for the direct-mapped instruction cache. It owns the tag and valid arrays, performs hit detection on the fetch PC, and drives INSTRUCTION_CACHE_READY back to fetch. On a miss it issues a line request to the memory side, collects a burst of words, and writes them into the external cache data RAM. It also handles whole-cache invalidation (FLUSH, e.g. fence.i).

Parameters:
ADDR_WIDTH, 32, PC and memory address width.
LINES, 64, number of cache lines; power of two.
LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
CLK  in  1  clock; everything is on the rising edge.
RST  in  1  reset; synchronous, active-high.
PC  in  ADDR_WIDTH  fetch address, word aligned.
PC_VALID  in  1  PC is a real fetch request.
INSTRUCTION_CACHE_STALL  in  1  pipeline stall; blocks launch of a new refill.
FLUSH  in  1  invalidate all lines.
INSTRUCTION_CACHE_READY  out  1  data RAM output at DATA_RADDR is a valid hit this cycle.
DATA_RADDR  out  IW+OW  {index, word offset} of PC, combinational.
DATA_WE  out  1  data RAM write strobe.
DATA_WADDR  out  IW+OW  {refill index, beat count}.
DATA_WDATA  out  32  equals MEM_DATA.
MEM_REQ  out  1  line-fill request.
MEM_ADDR  out  ADDR_WIDTH  line-aligned miss address; low OW+2 bits are zero.
MEM_ACK  in  1  request accepted.
MEM_DATA  in  32  refill beat.
MEM_DATA_VALID  in  1  beat present.
REFILL_BUSY  out  1  state is not LOOKUP.

Behaviour:
- Field widths: OW = log2(LINE_WORDS), IW = log2(LINES), TW = ADDR_WIDTH - IW - OW - 2.
- Address fields: offset = PC[OW+1:2], index = PC[IW+OW+1:OW+2], tag = upper TW bits.
- hit = PC_VALID & valid[index] & (tag_array[index] == tag).
- Reset: state LOOKUP, all valid bits 0, MEM_REQ 0, DATA_WE 0, beat counter 0, pending-flush 0. The tag array is not reset.
- Reset is honoured in any state. An in-flight refill is abandoned, and later MEM_DATA_VALID beats are ignored in LOOKUP.
- Single state machine: LOOKUP, MISS_REQ, REFILL, UPDATE.
- LOOKUP:
  - INSTRUCTION_CACHE_READY = hit, combinational. Hit latency is 0 cycles relative to the data RAM read.
  - FLUSH has priority: all valid bits clear next cycle, no refill launched, READY=0 that cycle.
  - PC_VALID & ~hit & ~STALL & ~FLUSH: latch miss_addr = PC with low OW+2 bits zeroed; go to MISS_REQ.
  - Miss with STALL=1: stay in LOOKUP, READY=0.
- MISS_REQ:
  - MEM_REQ=1, MEM_ADDR=miss_addr, both held stable until MEM_ACK.
  - On MEM_ACK go to REFILL with counter 0. MEM_REQ deasserts the cycle after ACK.
- REFILL:
  - Each MEM_DATA_VALID cycle: DATA_WE=1, DATA_WADDR={miss index, counter}, counter+1.
  - Cycles without MEM_DATA_VALID are bubbles; nothing is written.
  - On beat LINE_WORDS-1: write tag_array[miss index] = miss tag, go to UPDATE. Counter wraps to 0.
- UPDATE (1 cycle):
  - valid[miss index] = ~pending_flush. If pending_flush=1, all valid bits clear instead.
  - Clear pending_flush, return to LOOKUP.
- READY=0 in every state other than LOOKUP.
- PC and STALL changes during MISS_REQ/REFILL/UPDATE are ignored. The current PC is re-looked-up on return to LOOKUP.
- FLUSH asserted outside LOOKUP sets pending_flush. The refill finishes, but the line is not validated and all lines are invalidated in UPDATE.
- Minimum miss penalty with ACK and beats back-to-back: 1 (REQ) + LINE_WORDS (beats) + 1 (UPDATE) cycles, then a hit in LOOKUP.
- Stall does not suspend an in-progress refill.

Decomposition:
- Package icache_pkg holds:
  - state enum {LOOKUP, MISS_REQ, REFILL, UPDATE}
  - localparams OW, IW, TW
  - functions/macros for field extraction: offset, index, tag, line_align
- One sub-module, icache_tag_array:
  - LINES x TW register array plus valid vector
  - one combinational read port, one write port
  - synchronous clear-all input driven by reset and flush
- The controller FSM, beat counter and memory handshake stay in icache_refill_controller.

Test Plan:
- Cold miss: reset, then PC=0x0000_1004, PC_VALID=1, ACK in 1 cycle, 4 beats 0xA0..0xA3 back-to-back.
  -> MEM_ADDR=0x0000_1000; DATA_WE on 4 consecutive cycles, WADDR index 0, offsets 0..3; READY=1 exactly 7 cycles after the request; DATA_RADDR={0,1}.
- Hit path: after the fill above, PC=0x0000_100C -> READY=1 same cycle, no MEM_REQ. PC=0x0000_200C (same index, other tag) -> miss, MEM_ADDR=0x0000_2000.
- Handshake bubbles: ACK delayed 3 cycles, beats with 2-cycle gaps.
  -> MEM_REQ and MEM_ADDR stable until ACK; exactly 4 DATA_WE pulses; no write during gaps; PC changes during the refill are ignored.
- Stall gating: a miss with STALL=1 for 5 cycles -> no MEM_REQ, READY=0. STALL drops -> MEM_REQ next cycle.
- Flush: FLUSH asserted on the 2nd beat of a refill -> refill completes, then valid vector is all 0 and the refilled PC misses again. FLUSH in LOOKUP after a hit -> the next access to the same PC misses.
- Reset mid-refill: RST after beat 1 -> MEM_REQ=0, REFILL_BUSY=0 next cycle; beats 2-3 produce no DATA_WE; the same PC then misses.
